shm_unloader: RTL and testbench

- Host-side drain engine that reads result rows out of shared memory and streams them off-chip as 32-bit words over a valid/ready interface.
- It is the read-out counterpart of the ELECOMP_W2SHM write path: the elementwise array writes 128-bit rows into shared memory, and this block reads them back.
- It shares the shared-memory address/ren port with the controller through an external mux. It owns the port only while busy=1.

---
 rtl/shm_unloader_if.sv | 32 +++
 rtl/shm_unloader.sv | 122 ++++++++++++
 tb/tb_shm_unloader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/shm_unloader_if.sv
// Bus bundle for the shared-memory drain engine: control, shared-memory
// read port and the 32-bit valid/ready output stream.
interface shm_unloader_if #(
    parameter int ADDR_W = 6,
    parameter int ROW_W  = 128,
    parameter int WORD_W = 32
) ();
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   row_count;
    logic              shm_ren;
    logic [ADDR_W-1:0] shm_a;
    logic [ROW_W-1:0]  shm_q;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    // Engine side
    modport master (
        input  start, base_addr, row_count, shm_q, out_ready,
        output shm_ren, shm_a, out_valid, out_data, out_last, busy, done
    );

    // Controller / memory / downstream side
    modport slave (
        output start, base_addr, row_count, shm_q, out_ready,
        input  shm_ren, shm_a, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/shm_unloader.sv
// Drains rows from shared memory and streams them out as 32-bit words,
// lane 0 (bits [31:0]) first. One row is in flight at a time; all outputs
// are registered.
module shm_unloader #(
    parameter int ADDR_W = 6,
    parameter int ROW_W  = 128,
    parameter int WORD_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    shm_unloader_if.master bus
);
    localparam int LANES  = ROW_W / WORD_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [ADDR_W:0]   ONE_ROW   = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, FIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [ROW_W-1:0]  row_reg;
    logic [LANE_W-1:0] lane;

    logic [LANE_W-1:0] lane_nx;
    logic [WORD_W-1:0] word_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [ADDR_W:0]   remaining_nx;
    logic              xfer;

    // Next-lane word select and per-row bookkeeping arithmetic
    always_comb begin
        lane_nx      = lane + 1'b1;
        word_nx      = row_reg[lane_nx*WORD_W +: WORD_W];
        addr_nx      = addr + 1'b1;
        remaining_nx = remaining - 1'b1;
        xfer         = bus.out_valid && bus.out_ready;
    end

    // Drain FSM; outputs are computed for the state being entered so they
    // appear registered and aligned with that state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            row_reg       <= '0;
            lane          <= '0;
            bus.shm_ren   <= 1'b0;
            bus.shm_a     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.row_count != '0) begin
                            addr        <= bus.base_addr;
                            remaining   <= bus.row_count;
                            bus.shm_ren <= 1'b1;
                            bus.shm_a   <= bus.base_addr;
                            bus.busy    <= 1'b1;
                            state       <= READ;
                        end else begin
                            bus.done <= 1'b1;
                            state    <= FIN;
                        end
                    end
                end
                READ: begin
                    bus.shm_ren <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: begin
                    row_reg       <= bus.shm_q;
                    lane          <= '0;
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= bus.shm_q[WORD_W-1:0];
                    bus.out_last  <= (LAST_LANE == '0) && (remaining == ONE_ROW);
                    state         <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        if (lane != LAST_LANE) begin
                            lane         <= lane_nx;
                            bus.out_data <= word_nx;
                            bus.out_last <= (lane_nx == LAST_LANE) && (remaining == ONE_ROW);
                        end else begin
                            remaining     <= remaining_nx;
                            addr          <= addr_nx;
                            bus.out_valid <= 1'b0;
                            bus.out_data  <= '0;
                            bus.out_last  <= 1'b0;
                            if (remaining_nx != '0) begin
                                bus.shm_ren <= 1'b1;
                                bus.shm_a   <= addr_nx;
                                state       <= READ;
                            end else begin
                                bus.shm_a <= '0;
                                bus.busy  <= 1'b0;
                                bus.done  <= 1'b1;
                                state     <= FIN;
                            end
                        end
                    end
                end
                FIN: begin
                    addr      <= '0;
                    remaining <= '0;
                    lane      <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shm_unloader.sv
// Scoreboard bench for shm_unloader: stimulus pushes expected words and
// row addresses; a negedge monitor pops and compares on each transfer/read.
module tb_shm_unloader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    shm_unloader_if #(.ADDR_W(6), .ROW_W(128), .WORD_W(32)) bus ();

    shm_unloader #(.ADDR_W(6), .ROW_W(128), .WORD_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic [127:0] mem [64];
    exp_t         exp_q [$];
    int           exp_addr [$];
    int           checks = 0;
    int           errors = 0;
    int           done_cnt = 0;
    logic         stalled = 1'b0;
    logic [31:0]  held_data;
    logic         held_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous shared-memory model: data valid the cycle after ren
    always @(posedge clk) begin
        if (bus.shm_ren === 1'b1) bus.shm_q <= mem[bus.shm_a];
    end

    // Monitor: address reads, transfers, stall stability, done pulses
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            stalled = 1'b0;
        end else begin
            if (bus.shm_ren === 1'b1) begin
                check("ren_expected", 64'(exp_addr.size() > 0), 64'd1);
                if (exp_addr.size() > 0) check("shm_a", 64'(bus.shm_a), 64'(exp_addr.pop_front()));
            end
            if (bus.done === 1'b1) done_cnt++;
            if (stalled) check("valid_held", 64'(bus.out_valid), 64'd1);
            if (bus.out_valid === 1'b1) begin
                if (stalled) begin
                    check("stall_data", 64'(bus.out_data), 64'(held_data));
                    check("stall_last", 64'(bus.out_last), 64'(held_last));
                end
                if (bus.out_ready === 1'b1) begin
                    exp_t e;
                    check("word_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("out_data", 64'(bus.out_data), 64'(e.data));
                        check("out_last", 64'(bus.out_last), 64'(e.last));
                    end
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_data = bus.out_data;
                    held_last = bus.out_last;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic push_exp(input int base, input int count);
        for (int r = 0; r < count; r++) begin
            int a;
            a = (base + r) % 64;
            exp_addr.push_back(a);
            for (int j = 0; j < 4; j++) begin
                exp_t e;
                e.data = mem[a][j*32 +: 32];
                e.last = (r == count - 1) && (j == 3);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start(input int base, input int count);
        bus.base_addr = 6'(base);
        bus.row_count = 7'(count);
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 per cycle
    task automatic run_drain(input int base, input int count, input int mode);
        logic [3:0] pat;
        logic       seen;
        int         d0;
        pat  = 4'b1001;
        seen = 1'b0;
        d0   = done_cnt;
        push_exp(base, count);
        bus.out_ready = 1'b1;
        pulse_start(base, count);
        for (int c = 0; c < count * 30 + 20 && !seen; c++) begin
            bus.out_ready = (mode == 1) ? pat[c % 4] : 1'b1;
            if (bus.done === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("busy_at_done", 64'(bus.busy), 64'd0);
        check("words_left", 64'(exp_q.size()), 64'd0);
        check("reads_left", 64'(exp_addr.size()), 64'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("done_single", 64'(bus.done), 64'd0);
        check("done_count", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        logic ren_exp, val_exp, last_exp, done_exp, busy_exp;
        int   d0;
        logic seen;

        for (int r = 0; r < 64; r++)
            for (int j = 0; j < 4; j++)
                mem[r][j*32 +: 32] = {8'(r), 8'(j), 16'(r * 97 + j * 13) ^ 16'h5A3C};
        mem[5] = 128'h44444444_33333333_22222222_11111111;

        bus.start = 1'b0; bus.base_addr = '0; bus.row_count = '0;
        bus.out_ready = 1'b1; bus.shm_q = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ren", 64'(bus.shm_ren), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_last", 64'(bus.out_last), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Single row, cycle-exact timing
        d0 = done_cnt;
        push_exp(5, 1);
        pulse_start(5, 1);
        check("t1_shm_a", 64'(bus.shm_a), 64'd5);
        for (int k = 1; k <= 7; k++) begin
            ren_exp  = (k == 1);
            val_exp  = (k >= 3 && k <= 6);
            last_exp = (k == 6);
            done_exp = (k == 7);
            busy_exp = (k <= 6);
            check($sformatf("t1_ren_c%0d", k), 64'(bus.shm_ren), 64'(ren_exp));
            check($sformatf("t1_valid_c%0d", k), 64'(bus.out_valid), 64'(val_exp));
            check($sformatf("t1_last_c%0d", k), 64'(bus.out_last), 64'(last_exp));
            check($sformatf("t1_done_c%0d", k), 64'(bus.done), 64'(done_exp));
            check($sformatf("t1_busy_c%0d", k), 64'(bus.busy), 64'(busy_exp));
            @(posedge clk); #1;
        end
        check("t1_words_left", 64'(exp_q.size()), 64'd0);
        check("t1_done_count", 64'(done_cnt - d0), 64'd1);

        // Address wrap 62, 63, 0
        run_drain(62, 3, 0);

        // Backpressure over two rows
        run_drain(7, 2, 1);

        // Zero length, plus start ignored during FIN
        d0 = done_cnt;
        pulse_start(9, 0);
        check("z_done", 64'(bus.done), 64'd1);
        check("z_busy", 64'(bus.busy), 64'd0);
        check("z_ren", 64'(bus.shm_ren), 64'd0);
        bus.row_count = 7'd1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("z_fin_start_ren", 64'(bus.shm_ren), 64'd0);
        check("z_fin_start_busy", 64'(bus.busy), 64'd0);
        check("z_done_low", 64'(bus.done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("z_done_count", 64'(done_cnt - d0), 64'd1);

        // Start ignored in SEND, then reset abort mid-SEND
        d0 = done_cnt;
        push_exp(10, 2);
        bus.out_ready = 1'b1;
        pulse_start(10, 2);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (bus.out_valid === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("ab_valid_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        bus.base_addr = 6'd30; bus.row_count = 7'd5; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("ab_still_send", 64'(bus.out_valid), 64'd1);
        check("ab_no_ren", 64'(bus.shm_ren), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("ab_valid", 64'(bus.out_valid), 64'd0);
        check("ab_busy", 64'(bus.busy), 64'd0);
        check("ab_ren", 64'(bus.shm_ren), 64'd0);
        check("ab_done", 64'(bus.done), 64'd0);
        exp_q.delete();
        exp_addr.delete();
        repeat (4) @(posedge clk);
        #1;
        check("ab_no_done", 64'(done_cnt - d0), 64'd0);
        check("ab_idle_busy", 64'(bus.busy), 64'd0);
        run_drain(20, 1, 0);

        // Full memory drain
        run_drain(0, 64, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
